// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: register map, bit positions,
// capture FSM states and FIFO entry width.
package uart_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_KLO    = 3'd3;
  localparam logic [2:0] ADDR_KMID   = 3'd4;
  localparam logic [2:0] ADDR_KHI    = 3'd5;

  localparam int ST_AVAIL = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_PERR  = 2;
  localparam int ST_FERR  = 3;
  localparam int ST_OVF   = 4;

  localparam int CTRL_EIGHT  = 0;
  localparam int CTRL_PEN    = 1;
  localparam int CTRL_EVEN   = 2;
  localparam int CTRL_FLUSH  = 3;
  localparam int CTRL_RX_IE  = 4;
  localparam int CTRL_ERR_IE = 5;

  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    WAIT  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO; flush has priority over push/pop, and a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module rx_fifo #(
  parameter int W = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_pop_s;
  logic          do_push_s;

  assign full      = (count_r == CW'(D));
  assign empty     = (count_r == {CW{1'b0}});
  assign head      = mem[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Host-side UART receive controller: config registers, frame capture FSM, receive FIFO.
// Optional feature macro: UART_RX_IRQ_EN enables the interrupt and CTRL[5:4].
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [18:0] K_RESET = 19'd10417
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        irq,
  input  logic [7:0]  rx_data,
  input  logic        rxrdy,
  input  logic        ferr,
  input  logic        perr,
  input  logic        ovf,
  output logic        clr,
  output logic [18:0] k,
  output logic        eight,
  output logic        pen,
  output logic        even
);

  rx_state_t          state_r;
  logic               ovf_r;
  logic [ENTRY_W-1:0] head_s;
  logic               full_s;
  logic               empty_s;
  logic               rd_hit_s;
  logic               we_hit_s;
  logic               push_s;
  logic               pop_s;
  logic               flush_s;
  logic               drop_s;
  logic               ovf_set_s;
  logic               ovf_clr_s;
  logic               head_perr_s;
  logic               head_ferr_s;
  logic               irq_nxt_s;
  logic [7:0]         status_s;
  logic [7:0]         ctrl_rd_s;
  logic [7:0]         rdata_s;
`ifdef UART_RX_IRQ_EN
  logic               rx_ie_r;
  logic               err_ie_r;
`endif

  rx_fifo #(
    .W (ENTRY_W),
    .D (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   ({ferr, perr, rx_data}),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Bus decode, capture qualifiers, status/readback muxing and interrupt term.
  always_comb begin
    rd_hit_s    = cs & rd;
    we_hit_s    = cs & we;
    pop_s       = rd_hit_s & (addr == ADDR_DATA);
    push_s      = (state_r == IDLE) & rxrdy;
    flush_s     = we_hit_s & (addr == ADDR_CTRL) & din[CTRL_FLUSH];
    drop_s      = push_s & full_s & ~pop_s;
    ovf_set_s   = push_s & (ovf | drop_s);
    ovf_clr_s   = we_hit_s & (addr == ADDR_STATUS) & din[ST_OVF];
    head_perr_s = ~empty_s & head_s[8];
    head_ferr_s = ~empty_s & head_s[9];
    status_s    = {3'b000, ovf_r, head_ferr_s, head_perr_s, full_s, ~empty_s};
`ifdef UART_RX_IRQ_EN
    ctrl_rd_s   = {2'b00, err_ie_r, rx_ie_r, 1'b0, even, pen, eight};
    irq_nxt_s   = (rx_ie_r & ~empty_s) | (err_ie_r & (ovf_r | head_perr_s | head_ferr_s));
`else
    ctrl_rd_s   = {5'b00000, even, pen, eight};
    irq_nxt_s   = 1'b0;
`endif
    case (addr)
      ADDR_DATA:   rdata_s = empty_s ? 8'h00 : head_s[7:0];
      ADDR_STATUS: rdata_s = status_s;
      ADDR_CTRL:   rdata_s = ctrl_rd_s;
      ADDR_KLO:    rdata_s = k[7:0];
      ADDR_KMID:   rdata_s = k[15:8];
      ADDR_KHI:    rdata_s = {5'b00000, k[18:16]};
      default:     rdata_s = 8'h00;
    endcase
  end

  // Host-writable configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= K_RESET;
      eight <= 1'b1;
      pen   <= 1'b0;
      even  <= 1'b0;
`ifdef UART_RX_IRQ_EN
      rx_ie_r  <= 1'b0;
      err_ie_r <= 1'b0;
`endif
    end else if (we_hit_s) begin
      case (addr)
        ADDR_CTRL: begin
          eight <= din[CTRL_EIGHT];
          pen   <= din[CTRL_PEN];
          even  <= din[CTRL_EVEN];
`ifdef UART_RX_IRQ_EN
          rx_ie_r  <= din[CTRL_RX_IE];
          err_ie_r <= din[CTRL_ERR_IE];
`endif
        end
        ADDR_KLO:  k[7:0]   <= din;
        ADDR_KMID: k[15:8]  <= din;
        ADDR_KHI:  k[18:16] <= din[2:0];
        default:   k        <= k;
      endcase
    end
  end

  // Capture FSM: one push per frame, then a single clr pulse, then wait for rxrdy to drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      clr     <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      ovf_r <= (ovf_r & ~ovf_clr_s) | ovf_set_s;
      case (state_r)
        IDLE: begin
          clr <= 1'b0;
          if (rxrdy) state_r <= CLEAR;
        end
        CLEAR: begin
          clr     <= 1'b1;
          state_r <= WAIT;
        end
        WAIT: begin
          clr <= 1'b0;
          if (!rxrdy) state_r <= IDLE;
        end
        default: begin
          clr     <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 8'h00;
      irq  <= 1'b0;
    end else begin
      if (rd_hit_s) dout <= rdata_s;
      irq <= irq_nxt_s;
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Host-side controller for the UART receive path. Configures the receive engine (baud divisor `k`, `eight`, `pen`, `even`) from host-writable registers. Sequences each completed frame out of the engine: captures data and error flags into a receive FIFO, then pulses `clr`. Presents data, status and an optional interrupt on a simple 8-bit strobe bus.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, 2..64.
- `K_RESET`, 19'd10417 — reset value of the baud divisor `k`.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — asynchronous, active-high reset.
- `cs` in 1 — bus select; qualifies `rd` and `we`.
- `rd` in 1 — single-cycle read strobe.
- `we` in 1 — single-cycle write strobe.
- `addr` in 3 — register address.
- `din` in 8 — write data.
- `dout` out 8 — registered read data.
- `irq` out 1 — interrupt request, level.
- `rx_data` in 8 — engine data.
- `rxrdy`, `ferr`, `perr`, `ovf` in 1 each — engine flags.
- `clr` out 1 — engine flag clear, one-cycle pulse.
- `k` out 19 — baud divisor.
- `eight`, `pen`, `even` out 1 each — frame format.

## Operation
Register map (`addr`):
- 0 DATA: read pops the FIFO head. Read when empty returns 0x00 with no state change.
- 1 STATUS:
  - Read: [0] avail (FIFO not empty), [1] full, [2] head PERR, [3] head FERR, [4] OVF sticky, [7:5] 0.
  - Write: writing 1 to bit 4 clears OVF.
- 2 CTRL, R/W:
  - [0] eight, [1] pen, [2] even.
  - [3] flush: write-only, self-clearing; empties the FIFO; reads 0.
  - [4] rx_ie, [5] err_ie.
  - [7:6] 0.
- 3/4/5: `k[7:0]`, `k[15:8]`, `k[18:16]` (upper bits of addr 5 read 0). Each write takes effect immediately.
- Addresses 6–7: reads return 0; writes are ignored.
- Config writes during a frame take effect immediately. Software guarantees the line is idle when reconfiguring.

FIFO entry: 10 bits, `{ferr, perr, rx_data}`.

Capture FSM:
- IDLE: when `rxrdy`=1, push an entry (if not full) and OR engine `ovf` into OVF sticky. If full, drop the entry and set OVF. Go to CLEAR.
- CLEAR: assert `clr` for this cycle; go to WAIT.
- WAIT: hold until `rxrdy`=0, then go to IDLE.
- Rule: `clr` is asserted only in CLEAR.

Boundary conditions:
- Push and pop in the same cycle: both occur; count unchanged.
- Full and pop with push: allowed, no drop.
- Flush concurrent with push: flush wins and the FIFO ends empty. OVF is unaffected by flush.
- Pointers wrap modulo `DEPTH`. Count width is clog2(`DEPTH`)+1.

Reset values:
- `dout`=0, `irq`=0, `clr`=0.
- `k`=`K_RESET`, `eight`=1, `pen`=0, `even`=0, ie bits 0.
- FIFO empty, OVF 0, FSM in IDLE.
- Reset mid-frame discards FIFO contents and returns the FSM to IDLE. The engine is reset by the same `rst`.

## Timing
- `dout` is valid the cycle after the `rd` strobe.
- Pop takes effect at the `rd` edge; `dout` holds the popped value.
- `rxrdy` sampled high at edge n → entry visible (avail=1) after edge n. `clr` is high from edge n+1 to edge n+2.
- Minimum frame turnaround is 3 cycles, far below one bit time.
- `irq` is registered and updates one cycle after its inputs change.

## Configuration
- `UART_RX_IRQ_EN` defined: `irq` = (rx_ie & avail) | (err_ie & (OVF | head PERR | head FERR)). CTRL[5:4] are R/W.
- Undefined: `irq` is tied to 0. CTRL[5:4] read 0 and writes to them are ignored.

## Structure
- Shared package `uart_pkg`:
  - register address constants;
  - CTRL and STATUS bit positions;
  - FSM state typedef (IDLE/CLEAR/WAIT);
  - FIFO entry width constant (10).
- One sub-module, `rx_fifo`: synchronous FIFO parameterised by width and depth, with push, pop, flush, full, empty and head outputs.

## Test plan
- Reset → `k`=10417, CTRL reads 0x01, STATUS reads 0x00, `clr`=0, `irq`=0.
- Write 0x56/0x01/0x00 to addr 3/4/5 → `k`=342. Write CTRL=0x03 → `eight`=1, `pen`=1, `even`=0.
- `rxrdy` pulse with `rx_data`=0xA5 → `clr` pulses exactly once at n+1. STATUS=0x01. DATA read returns 0xA5, then STATUS=0x00.
- `DEPTH`+1 frames with no reads → STATUS=0x13. The first `DEPTH` bytes read back in order; the last byte is lost. Write 0x10 to STATUS → OVF clears.
- Frame with `perr`=1, `ferr`=1 → STATUS=0x0D. With `UART_RX_IRQ_EN` and CTRL=0x21, `irq`=1. Pop → `irq`=0.
- DATA read in the same cycle as a push with FIFO full → no drop, count unchanged. Flush with FIFO holding 3 entries → STATUS avail=0.
